// File: rtl/axil_read_file_pkg.sv
// Shared definitions for the AXI4-Lite read-file block: master FSM state
// encoding and AXI response codes.
package axil_read_file_pkg;

    // Master FSM state type, kept as plain localparam constants for
    // compatibility with older tooling in the codebase.
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ADDR = 2'd1;
    localparam state_t DATA = 2'd2;
    localparam state_t DONE = 2'd3;

    // AXI response codes used on the R channel.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_slave_regs.sv
// Read-only AXI4-Lite slave: four word registers and the AR/R channel logic.
// Optional feature macro: AXIL_PROT_CHECK_EN -- reads of word 3 with an
// unprivileged arprot return SLVERR and zero data.
module axil_slave_regs
    import axil_read_file_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] REG0_INIT  = 32'h1111_1111,
    parameter logic [DATA_WIDTH-1:0] REG1_INIT  = 32'h2222_2222,
    parameter logic [DATA_WIDTH-1:0] REG2_INIT  = 32'h3333_3333,
    parameter logic [DATA_WIDTH-1:0] REG3_INIT  = 32'h4444_4444
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  arvalid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    output logic                  arready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] data
);

    // NOTE: the register bank has no write path, so its contents are the
    // INIT constants themselves; no storage exists and nothing needs a reset.
    logic [DATA_WIDTH-1:0] reg_sel;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic [1:0]            resp_sel;
    logic [1:0]            word_q;
    logic                  ar_accept;
    logic                  ar_handshake;

    // A new address is taken only when the slave is neither acknowledging
    // nor holding read data.
    assign ar_accept    = arvalid && !arready && !rvalid;
    assign ar_handshake = arvalid && arready;

    // Select the register addressed by the latched word index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        reg_sel = REG0_INIT;
        case (word_q)
            2'd0:    reg_sel = REG0_INIT;
            2'd1:    reg_sel = REG1_INIT;
            2'd2:    reg_sel = REG2_INIT;
            2'd3:    reg_sel = REG3_INIT;
            default: reg_sel = REG0_INIT;
        endcase
    end

`ifdef AXIL_PROT_CHECK_EN
    logic [2:0] prot_q;

    // Word 3 is privileged: unprivileged reads get SLVERR and zero data.
    always_comb begin
        rdata_sel = reg_sel;
        resp_sel  = RESP_OKAY;
        if (word_q == 2'd3 && !prot_q[0]) begin
            rdata_sel = '0;
            resp_sel  = RESP_SLVERR;
        end
    end

    // Capture the protection bits alongside the address.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prot_q <= 3'b000;
        end else if (ar_accept) begin
            prot_q <= arprot;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^araddr[1:0];
`else
    // Protection is ignored; every read returns the register with OKAY.
    always_comb begin
        rdata_sel = reg_sel;
        resp_sel  = RESP_OKAY;
    end

    logic unused_in_bits;
    assign unused_in_bits = ^{araddr[1:0], arprot};
`endif

    // AR acceptance, R channel data/valid and the selected-register view.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!aresetn) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            word_q  <= 2'd0;
            data    <= '0;
        end else begin
            arready <= 1'b0;
            if (ar_accept) begin
                arready <= 1'b1;
                word_q  <= araddr[3:2];
            end
            if (ar_handshake) begin
                rvalid <= 1'b1;
                rdata  <= rdata_sel;
                rresp  <= resp_sel;
                data   <= reg_sel;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axil_read_file.sv
// AXI4-Lite read master plus its read-only register slave. The master reads
// ADDRESS once after reset and again on every start pulse seen while idle.
// Optional feature macro: AXIL_PROT_CHECK_EN (forwarded to axil_slave_regs).
module axil_read_file
    import axil_read_file_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    ADDRESS    = 12,
    parameter logic [DATA_WIDTH-1:0] REG0_INIT  = 32'h1111_1111,
    parameter logic [DATA_WIDTH-1:0] REG1_INIT  = 32'h2222_2222,
    parameter logic [DATA_WIDTH-1:0] REG2_INIT  = 32'h3333_3333,
    parameter logic [DATA_WIDTH-1:0] REG3_INIT  = 32'h4444_4444
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [2:0]            arprot,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic [1:0]            rresp_out,
    output logic [DATA_WIDTH-1:0] data
);

    localparam logic [ADDR_WIDTH-1:0] AR_ADDR = ADDR_WIDTH'(ADDRESS);

    state_t                state;
    state_t                state_nxt;
    logic                  armed;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    // Channel controls and status decode straight from the state, so reset
    // clears them the instant the state register clears.
    assign arvalid = (state == ADDR);
    assign araddr  = AR_ADDR;
    assign rready  = (state == DATA);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Next-state logic: armed gives the automatic read after reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed || start) state_nxt = ADDR;
            ADDR:    if (arready)        state_nxt = DATA;
            DATA:    if (rvalid)         state_nxt = DONE;
            DONE:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // State register; armed is only ever high in the first cycle after
    // reset, where the FSM is guaranteed to be in IDLE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            armed <= 1'b1;
        end else begin
            state <= state_nxt;
            armed <= 1'b0;
        end
    end

    // Capture read data and response on the R handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_out <= '0;
            rresp_out <= RESP_OKAY;
        end else if (state == DATA && rvalid) begin
            rdata_out <= rdata;
            rresp_out <= rresp;
        end
    end

    axil_slave_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG0_INIT  (REG0_INIT),
        .REG1_INIT  (REG1_INIT),
        .REG2_INIT  (REG2_INIT),
        .REG3_INIT  (REG3_INIT)
    ) u_slave (
        .aclk    (aclk),
        .aresetn (aresetn),
        .arvalid (arvalid),
        .araddr  (araddr),
        .arprot  (arprot),
        .arready (arready),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rready  (rready),
        .data    (data)
    );

endmodule

// File: tb/tb_axil_read_file.sv
// Self-checking bench for axil_read_file. Two instances share stimulus: the
// default (ADDRESS=12) and ADDRESS=5. Expectations come from a transaction
// timeline model: trigger at cycle T -> busy T+1..T+4, arvalid T+1..T+2,
// arready T+2, rvalid/rready T+3, data from T+3, done and captured data T+4.
// Honours AXIL_PROT_CHECK_EN when the bench is built with it.
module tb_axil_read_file;

    localparam int NCYC     = 1500;
    localparam int ADDRS[2] = '{12, 5};
`ifdef AXIL_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic [2:0]  arprot;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] rdata_out_a, data_a, rdata_out_b, data_b;
    logic [1:0]  rresp_out_a, rresp_out_b;

    axil_read_file dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .arprot    (arprot),
        .busy      (busy_a),
        .done      (done_a),
        .rdata_out (rdata_out_a),
        .rresp_out (rresp_out_a),
        .data      (data_a)
    );

    axil_read_file #(.ADDRESS(5)) dut5 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .arprot    (arprot),
        .busy      (busy_b),
        .done      (done_b),
        .rdata_out (rdata_out_b),
        .rresp_out (rresp_out_b),
        .data      (data_b)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int          cyc        = 0;
    int          trig       = -100;
    int          n_trig     = 0;
    int          reset_left = 0;
    int          burst      = 0;
    bit          armed      = 1'b1;
    bit          did_mid_reset = 1'b0;
    logic [2:0]  trig_prot  = 3'b000;
    logic [31:0] exp_rdata_out[2];
    logic [1:0]  exp_rresp_out[2];
    logic [31:0] exp_data[2];
    logic [31:0] inits[4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    // Previous-cycle channel values for protocol checks.
    logic        prev_arvalid, prev_rvalid, prev_arready;
    logic [3:0]  prev_araddr;
    logic [31:0] prev_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, got, exp);
    endtask

    // What a read of byte address addr with protection prot should yield.
    function automatic void model_read(input int addr, input logic [2:0] prot,
                                       output logic [31:0] rd, output logic [1:0] rs,
                                       output logic [31:0] dv);
        int word;
        word = (addr / 4) % 4;
        dv   = inits[word];
        rd   = dv;
        rs   = 2'b00;
        if (PROT_EN && word == 3 && prot[0] == 1'b0) begin
            rd = 32'h0;
            rs = 2'b10;
        end
    endfunction

    function automatic bit busy_m();
        return (cyc >= trig + 1) && (cyc <= trig + 4);
    endfunction

    task automatic model_reset();
        trig  = -100;
        armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_rdata_out[i] = 32'h0;
            exp_rresp_out[i] = 2'b00;
            exp_data[i]      = 32'h0;
        end
        prev_arvalid = 1'b0;
        prev_rvalid  = 1'b0;
        prev_arready = 1'b0;
        prev_araddr  = 4'h0;
        prev_rdata   = 32'h0;
    endtask

    task automatic check_outputs(input int idx, input logic b, input logic d,
                                 input logic [31:0] rdo, input logic [1:0] rro,
                                 input logic [31:0] dat);
        string p;
        p = (idx == 0) ? "a." : "b.";
        check({p, "busy"},      32'(b),   32'(busy_m()));
        check({p, "done"},      32'(d),   32'(cyc == trig + 4));
        check({p, "rdata_out"}, rdo,      exp_rdata_out[idx]);
        check({p, "rresp_out"}, 32'(rro), 32'(exp_rresp_out[idx]));
        check({p, "data"},      dat,      exp_data[idx]);
    endtask

    task automatic check_cycle();
        logic [31:0] rd, dv;
        logic [1:0]  rs;
        for (int i = 0; i < 2; i++) begin
            model_read(ADDRS[i], trig_prot, rd, rs, dv);
            if (cyc == trig + 3) exp_data[i] = dv;
            if (cyc == trig + 4) begin
                exp_rdata_out[i] = rd;
                exp_rresp_out[i] = rs;
            end
        end
        check_outputs(0, busy_a, done_a, rdata_out_a, rresp_out_a, data_a);
        check_outputs(1, busy_b, done_b, rdata_out_b, rresp_out_b, data_b);

        // Internal AR/R channel timing of the default instance.
        model_read(ADDRS[0], trig_prot, rd, rs, dv);
        check("arvalid", 32'(dut.arvalid), 32'(cyc == trig + 1 || cyc == trig + 2));
        check("arready", 32'(dut.arready), 32'(cyc == trig + 2));
        check("rvalid",  32'(dut.rvalid),  32'(cyc == trig + 3));
        check("rready",  32'(dut.rready),  32'(cyc == trig + 3));
        if (cyc == trig + 1) check("araddr", 32'(dut.araddr), 32'(ADDRS[0]));
        if (cyc == trig + 3) begin
            check("rdata", dut.rdata, rd);
            check("rresp", 32'(dut.rresp), 32'(rs));
        end

        // Protocol rules.
        if (prev_arvalid && dut.arvalid) check("araddr_stable", 32'(dut.araddr), 32'(prev_araddr));
        if (prev_rvalid && dut.rvalid)   check("rdata_stable", dut.rdata, prev_rdata);
        if (prev_arready)                check("arready_single", 32'(dut.arready), 32'd0);
        prev_arvalid = dut.arvalid;
        prev_rvalid  = dut.rvalid;
        prev_arready = dut.arready;
        prev_araddr  = dut.araddr;
        prev_rdata   = dut.rdata;
    endtask

    // Everything must read zero immediately after reset asserts.
    task automatic check_reset_zero();
        check("rst.a.busy",      32'(busy_a),      32'd0);
        check("rst.a.done",      32'(done_a),      32'd0);
        check("rst.a.rdata_out", rdata_out_a,      32'd0);
        check("rst.a.rresp_out", 32'(rresp_out_a), 32'd0);
        check("rst.a.data",      data_a,           32'd0);
        check("rst.b.busy",      32'(busy_b),      32'd0);
        check("rst.b.rdata_out", rdata_out_b,      32'd0);
        check("rst.b.data",      data_b,           32'd0);
        check("rst.arvalid",     32'(dut.arvalid), 32'd0);
        check("rst.arready",     32'(dut.arready), 32'd0);
        check("rst.rvalid",      32'(dut.rvalid),  32'd0);
        check("rst.rready",      32'(dut.rready),  32'd0);
        check("rst.rdata",       dut.rdata,        32'd0);
    endtask

    initial begin
        aresetn    = 1'b0;
        start      = 1'b0;
        arprot     = 3'b000;
        reset_left = 2;
        model_reset();
        repeat (2) @(posedge aclk);

        for (int k = 0; k < NCYC; k++) begin
            @(negedge aclk);
            cyc++;
            check_cycle();

            // Reset control: one asynchronous reset while rvalid is high.
            if (!did_mid_reset && cyc > 300 && cyc == trig + 3) begin
                aresetn = 1'b0;
                start   = 1'b0;
                #1;
                check_reset_zero();
                model_reset();
                did_mid_reset = 1'b1;
                reset_left    = 3;
            end else if (reset_left > 0) begin
                reset_left--;
                if (reset_left == 0) aresetn = 1'b1;
            end

            // Random start pulses and bursts; arprot only changes while idle.
            if (aresetn) begin
                if (burst > 0) begin
                    start = 1'b1;
                    burst--;
                end else if ($urandom_range(0, 15) == 0) begin
                    start = 1'b1;
                    burst = $urandom_range(0, 7);
                end else begin
                    start = ($urandom_range(0, 9) == 0);
                end
                if (!busy_m()) begin
                    arprot = (n_trig < 2) ? 3'(n_trig) : 3'($urandom_range(0, 7));
                    if (armed || start) begin
                        trig      = cyc;
                        trig_prot = arprot;
                        armed     = 1'b0;
                        n_trig++;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
